// File: rtl/fetch_decode_stage.sv
// Instruction fetch and decode front end: program counter, word-addressed
// instruction memory with a load port, PC+4 / branch-target adders and the
// IF/ID register that splits the fetched instruction into MIPS fields.
module fetch_decode_stage #(
    parameter int unsigned DEPTH    = 1024,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pc_en,
    input  logic [1:0]  pc_sel,
    input  logic [31:0] jr_addr,
    input  logic        imem_we,
    input  logic [31:0] imem_waddr,
    input  logic [31:0] imem_wdata,
    output logic [31:0] pc,
    output logic [31:0] instr,
    output logic [31:0] pc_plus4,
    output logic [5:0]  opcode,
    output logic [4:0]  rs,
    output logic [4:0]  rt,
    output logic [4:0]  rd,
    output logic [4:0]  shamt,
    output logic [5:0]  funct,
    output logic [15:0] imm16,
    output logic [25:0] address,
    output logic [31:0] branch_target,
    output logic [31:0] jump_target
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        SEL_PC4    = 2'b00,
        SEL_BRANCH = 2'b01,
        SEL_JUMP   = 2'b10,
        SEL_JR     = 2'b11
    } pc_sel_t;

    logic [31:0]   mem [DEPTH];
    logic [AW-1:0] rd_idx;
    logic [AW-1:0] wr_idx;
    logic [31:0]   fetch_pc4;
    logic [31:0]   next_pc;
    logic [31:0]   ifid_instr;
    logic [31:0]   ifid_pc4;
    pc_sel_t       sel;

    // Address bits outside the word index are intentionally ignored.
    logic unused_waddr_bits;
    assign unused_waddr_bits = ^{imem_waddr[31:AW+2], imem_waddr[1:0]};

    assign rd_idx    = pc[AW+1:2];
    assign wr_idx    = imem_waddr[AW+1:2];
    assign instr     = mem[rd_idx];
    assign fetch_pc4 = pc + 32'd4;
    assign sel       = pc_sel_t'(pc_sel);

    // Program load port; memory is deliberately outside the reset domain.
    always_ff @(posedge clk) begin
        if (imem_we) begin
            mem[wr_idx] <= imem_wdata;
        end
    end

    // Next-PC mux; redirect targets come from the instruction in decode.
    always_comb begin
        next_pc = fetch_pc4;
        unique case (sel)
            SEL_PC4:    next_pc = fetch_pc4;
            SEL_BRANCH: next_pc = branch_target;
            SEL_JUMP:   next_pc = jump_target;
            SEL_JR:     next_pc = jr_addr;
        endcase
    end

    // Program counter, stalled when pc_en is low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc <= RESET_PC;
        end else if (pc_en) begin
            pc <= next_pc;
        end
    end

    // IF/ID register; cleared word decodes as a NOP.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ifid_instr <= '0;
            ifid_pc4   <= '0;
        end else if (pc_en) begin
            ifid_instr <= instr;
            ifid_pc4   <= fetch_pc4;
        end
    end

    assign pc_plus4 = ifid_pc4;
    assign opcode   = ifid_instr[31:26];
    assign rs       = ifid_instr[25:21];
    assign rt       = ifid_instr[20:16];
    assign rd       = ifid_instr[15:11];
    assign shamt    = ifid_instr[10:6];
    assign funct    = ifid_instr[5:0];
    assign imm16    = ifid_instr[15:0];
    assign address  = ifid_instr[25:0];

    assign branch_target = ifid_pc4 + {{14{ifid_instr[15]}}, ifid_instr[15:0], 2'b00};
    assign jump_target   = {ifid_pc4[31:28], ifid_instr[25:0], 2'b00};

endmodule

// File: tb/tb_fetch_decode_stage.sv
// Directed bench for fetch_decode_stage: reset state, field decode of R/I/J
// words, branch/jump/jr redirects, PC wrap, stall and mid-run reset.
module tb_fetch_decode_stage;

    logic        clk = 1'b0;
    logic        clk_run = 1'b0;
    logic        reset;
    logic        pc_en;
    logic [1:0]  pc_sel;
    logic [31:0] jr_addr;
    logic        imem_we;
    logic [31:0] imem_waddr;
    logic [31:0] imem_wdata;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc_plus4;
    logic [5:0]  opcode;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  rd;
    logic [4:0]  shamt;
    logic [5:0]  funct;
    logic [15:0] imm16;
    logic [25:0] address;
    logic [31:0] branch_target;
    logic [31:0] jump_target;

    int n_checks = 0;
    int n_errors = 0;

    fetch_decode_stage #(
        .DEPTH    (1024),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_en         (pc_en),
        .pc_sel        (pc_sel),
        .jr_addr       (jr_addr),
        .imem_we       (imem_we),
        .imem_waddr    (imem_waddr),
        .imem_wdata    (imem_wdata),
        .pc            (pc),
        .instr         (instr),
        .pc_plus4      (pc_plus4),
        .opcode        (opcode),
        .rs            (rs),
        .rt            (rt),
        .rd            (rd),
        .shamt         (shamt),
        .funct         (funct),
        .imm16         (imm16),
        .address       (address),
        .branch_target (branch_target),
        .jump_target   (jump_target)
    );

    always #5 if (clk_run) clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One rising edge, then settle 1 time unit past it.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic load(input logic [31:0] addr, input logic [31:0] data);
        imem_we    = 1'b1;
        imem_waddr = addr;
        imem_wdata = data;
        step();
        imem_we    = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset      = 1'b1;
        pc_en      = 1'b0;
        pc_sel     = 2'b00;
        jr_addr    = '0;
        imem_we    = 1'b0;
        imem_waddr = '0;
        imem_wdata = '0;
        #1;
        // Reset with clock stopped
        check("rst_pc",       pc,            32'h0);
        check("rst_opcode",   opcode,        32'h0);
        check("rst_rs",       rs,            32'h0);
        check("rst_rt",       rt,            32'h0);
        check("rst_rd",       rd,            32'h0);
        check("rst_shamt",    shamt,         32'h0);
        check("rst_funct",    funct,         32'h0);
        check("rst_imm16",    imm16,         32'h0);
        check("rst_address",  address,       32'h0);
        check("rst_pc4",      pc_plus4,      32'h0);
        check("rst_btarget",  branch_target, 32'h0);
        check("rst_jtarget",  jump_target,   32'h0);

        clk_run = 1'b1;
        // Program load while held in reset
        load(32'h0000_0000, 32'h012A_4020);
        load(32'h0000_0004, 32'h8D28_0004);
        load(32'h0000_0008, 32'h1000_FFFF);
        load(32'h0000_000C, 32'h0800_0010);
        load(32'h8000_0043, 32'h03E0_0008); // aliases word 16 (byte 0x40)
        load(32'h0000_0100, 32'h0000_0000);
        load(32'h0000_0FFC, 32'h2108_FFFF);
        check("held_pc", pc, 32'h0);

        reset = 1'b0;
        pc_en = 1'b1;
        #1;
        check("fetch0_instr", instr, 32'h012A_4020);

        step(); // R-type
        check("r_opcode", opcode,   32'h0);
        check("r_rs",     rs,       32'd9);
        check("r_rt",     rt,       32'd10);
        check("r_rd",     rd,       32'd8);
        check("r_shamt",  shamt,    32'h0);
        check("r_funct",  funct,    32'h20);
        check("r_pc4",    pc_plus4, 32'h4);
        check("r_pc",     pc,       32'h4);

        step(); // I-type lw
        check("i_opcode",  opcode,        32'h23);
        check("i_rs",      rs,            32'd9);
        check("i_rt",      rt,            32'd8);
        check("i_imm16",   imm16,         32'h4);
        check("i_btarget", branch_target, 32'h18);
        check("i_pc",      pc,            32'h8);

        step(); // beq backward
        check("b_pc4",     pc_plus4,      32'hC);
        check("b_btarget", branch_target, 32'h8);
        check("b_opcode",  opcode,        32'h4);
        pc_sel = 2'b01;
        step();
        check("b_taken_pc", pc,          32'h8);
        check("j_opcode",   opcode,      32'h2);
        check("j_address",  address,     32'h10);
        check("j_jtarget",  jump_target, 32'h40);
        pc_sel = 2'b10;
        step();
        check("j_taken_pc",  pc,    32'h40);
        check("wrap_instr",  instr, 32'h03E0_0008);
        pc_sel  = 2'b11;
        jr_addr = 32'h0000_0100;
        step();
        check("jr_pc",    pc,       32'h100);
        check("jr_rs",    rs,       32'd31);
        check("jr_funct", funct,    32'h8);
        check("jr_pc4",   pc_plus4, 32'h44);

        jr_addr = 32'hFFFF_FFFC;
        step();
        check("top_pc", pc, 32'hFFFF_FFFC);
        pc_sel = 2'b00;
        step(); // PC+4 wraps to zero
        check("wrap_pc",      pc,            32'h0);
        check("wrap_pc4",     pc_plus4,      32'h0);
        check("wrap_opcode",  opcode,        32'h8);
        check("wrap_imm16",   imm16,         32'hFFFF);
        check("wrap_btarget", branch_target, 32'hFFFF_FFFC);
        check("wrap_jtarget", jump_target,   32'h0423_FFFC);

        // Stall for three edges; a load to the fetched word shows through instr
        pc_en  = 1'b0;
        pc_sel = 2'b01;
        load(32'h0000_0000, 32'hAAAA_BBBB);
        step();
        step();
        check("stall_pc",     pc,       32'h0);
        check("stall_pc4",    pc_plus4, 32'h0);
        check("stall_opcode", opcode,   32'h8);
        check("stall_imm16",  imm16,    32'hFFFF);
        check("stall_instr",  instr,    32'hAAAA_BBBB);

        pc_en  = 1'b1;
        pc_sel = 2'b00;
        step();
        check("resume_pc",     pc,     32'h4);
        check("resume_opcode", opcode, 32'h2A);

        // Asynchronous reset mid-cycle, then a write under reset
        reset = 1'b1;
        #1;
        check("mrst_pc",      pc,            32'h0);
        check("mrst_opcode",  opcode,        32'h0);
        check("mrst_imm16",   imm16,         32'h0);
        check("mrst_pc4",     pc_plus4,      32'h0);
        check("mrst_btarget", branch_target, 32'h0);
        check("mrst_jtarget", jump_target,   32'h0);
        load(32'h0000_0000, 32'h1234_5678);
        check("mrst_write", instr, 32'h1234_5678);
        check("mrst_hold",  pc,    32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
